// File: rtl/sl_pkg.sv
// Shared sizing and types for the sliding-window datapath (address generator, controller, window buffer).
// No logic here: widths and typedefs only.
package sl_pkg;
    localparam int SL_ADDR_W     = 8;
    localparam int SL_FILT_LINES = 4;
    localparam int SL_POS_W      = 8;
    localparam int SL_STRIDE_W   = 4;
    localparam int SL_LINE_W     = $clog2(SL_FILT_LINES);

    typedef logic [SL_ADDR_W-1:0]   addr_t;
    typedef logic [SL_POS_W-1:0]    pos_t;
    typedef logic [SL_LINE_W-1:0]   line_t;
    typedef logic [SL_STRIDE_W-1:0] stride_t;
endpackage

// File: rtl/sl_window_addr_gen_if.sv
// Controller <-> address generator bus: start/config, counter enables, address and status levels.
// Outputs are combinational levels; the generator never stalls the controller.
interface sl_window_addr_gen_if
    import sl_pkg::*;
#(
    parameter int ADDR_W     = SL_ADDR_W,
    parameter int FILT_LINES = SL_FILT_LINES,
    parameter int POS_W      = SL_POS_W,
    parameter int STRIDE_W   = SL_STRIDE_W
) ();
    localparam int LINE_W = $clog2(FILT_LINES);

    logic                start;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [STRIDE_W-1:0] cfg_stride;
    logic [POS_W-1:0]    cfg_num_pos;
    logic                line_cntr_en;
    logic                windowpos_cntr_en;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   line_idx;
    logic [POS_W-1:0]    pos_idx;
    logic                cout_addr_generator;
    logic                ld_window_done;

    modport master (
        output start, cfg_base_addr, cfg_stride, cfg_num_pos, line_cntr_en, windowpos_cntr_en,
        input  addr, line_idx, pos_idx, cout_addr_generator, ld_window_done
    );

    modport slave (
        input  start, cfg_base_addr, cfg_stride, cfg_num_pos, line_cntr_en, windowpos_cntr_en,
        output addr, line_idx, pos_idx, cout_addr_generator, ld_window_done
    );
endinterface

// File: rtl/sl_mod_counter.sv
// Modulo counter 0..max_val with synchronous clear (priority over en); at_max is a combinational level.
// Latency: count updates one edge after en/clr; no backpressure, en is honoured every cycle.
module sl_mod_counter #(
    parameter int MOD_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [MOD_W-1:0] max_val,
    output logic [MOD_W-1:0] count,
    output logic             at_max
);
    logic [MOD_W-1:0] count_q;
    logic [MOD_W-1:0] count_d;

    assign at_max = (count_q == max_val);
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + MOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sl_window_addr_gen.sv
// Window line-address generator: addr = origin + line, origin steps by stride per window; zero latency.
// No backpressure: enables act on the next edge, start overrides both enables in its cycle.
module sl_window_addr_gen
    import sl_pkg::*;
#(
    parameter int ADDR_W     = SL_ADDR_W,
    parameter int FILT_LINES = SL_FILT_LINES,
    parameter int POS_W      = SL_POS_W,
    parameter int STRIDE_W   = SL_STRIDE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    sl_window_addr_gen_if.slave  bus
);
    localparam int               LINE_W   = $clog2(FILT_LINES);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(FILT_LINES - 1);

    logic [ADDR_W-1:0]   origin_q, origin_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [POS_W-1:0]    num_pos_q, num_pos_d;

    logic [LINE_W-1:0]   line_cnt;
    logic                line_at_max;
    logic [POS_W-1:0]    pos_cnt;
    logic                pos_at_max;

    sl_mod_counter #(.MOD_W(LINE_W)) u_line_cntr (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.line_cntr_en),
        .clr     (bus.start),
        .max_val (LINE_MAX),
        .count   (line_cnt),
        .at_max  (line_at_max)
    );

    // num_pos_q is never 0, so num_pos_q-1 cannot underflow.
    sl_mod_counter #(.MOD_W(POS_W)) u_pos_cntr (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.windowpos_cntr_en),
        .clr     (bus.start),
        .max_val (num_pos_q - POS_W'(1)),
        .count   (pos_cnt),
        .at_max  (pos_at_max)
    );

    always_comb begin
        origin_d  = origin_q;
        base_d    = base_q;
        stride_d  = stride_q;
        num_pos_d = num_pos_q;
        if (bus.start) begin
            origin_d  = bus.cfg_base_addr;
            base_d    = bus.cfg_base_addr;
            stride_d  = bus.cfg_stride;
            num_pos_d = (bus.cfg_num_pos == '0) ? POS_W'(1) : bus.cfg_num_pos;
        end else if (bus.windowpos_cntr_en) begin
            // Running sum instead of pos*stride; the last window folds back to base.
            origin_d = pos_at_max ? base_q : origin_q + ADDR_W'(stride_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            origin_q  <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            num_pos_q <= POS_W'(1);
        end else begin
            origin_q  <= origin_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            num_pos_q <= num_pos_d;
        end
    end

    assign bus.addr                = origin_q + ADDR_W'(line_cnt);
    assign bus.line_idx            = line_cnt;
    assign bus.pos_idx             = pos_cnt;
    assign bus.cout_addr_generator = line_at_max;
    assign bus.ld_window_done      = pos_at_max;
endmodule

// File: tb/tb_sl_window_addr_gen.sv
// Directed + random bench for sl_window_addr_gen against a closed-form model (base + pos*stride + line).
module tb_sl_window_addr_gen;
    import sl_pkg::*;

    localparam int FL = SL_FILT_LINES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sl_window_addr_gen_if bus_if ();

    sl_window_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: which window and which line we are on, plus latched config.
    int m_line, m_pos, m_base, m_stride, m_npos;

    task automatic model_reset();
        m_line = 0; m_pos = 0; m_base = 0; m_stride = 0; m_npos = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int exp_addr;
        exp_addr = (m_base + m_pos * m_stride + m_line) % (1 << SL_ADDR_W);
        check({tag, "_addr"}, 32'(bus_if.addr), exp_addr);
        check({tag, "_line"}, 32'(bus_if.line_idx), m_line);
        check({tag, "_pos"},  32'(bus_if.pos_idx), m_pos);
        check({tag, "_cout"}, 32'(bus_if.cout_addr_generator), (m_line == FL - 1) ? 1 : 0);
        check({tag, "_done"}, 32'(bus_if.ld_window_done), (m_pos == m_npos - 1) ? 1 : 0);
    endtask

    task automatic cyc(input string tag, input logic s, input addr_t b, input stride_t st,
                       input pos_t np, input logic le, input logic we);
        bus_if.start             = s;
        bus_if.cfg_base_addr     = b;
        bus_if.cfg_stride        = st;
        bus_if.cfg_num_pos       = np;
        bus_if.line_cntr_en      = le;
        bus_if.windowpos_cntr_en = we;
        @(posedge clk);
        if (s) begin
            m_line = 0; m_pos = 0; m_base = int'(b); m_stride = int'(st);
            m_npos = (np == 0) ? 1 : int'(np);
        end else begin
            if (le) m_line = (m_line + 1) % FL;
            if (we) m_pos = (m_pos == m_npos - 1) ? 0 : m_pos + 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.cfg_base_addr = '0; bus_if.cfg_stride = '0;
        bus_if.cfg_num_pos = '0; bus_if.line_cntr_en = 1'b0; bus_if.windowpos_cntr_en = 1'b0;
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #1 check_all("reset");
        check("reset_done_const", 32'(bus_if.ld_window_done), 1);
        @(negedge clk);
        rst = 1'b1;

        // Line stepping inside window 0
        cyc("t2_start", 1, 8'h10, 4'd2, 8'd3, 0, 0);
        check("t2_addr0", 32'(bus_if.addr), 32'h10);
        for (int i = 0; i < 3; i++) cyc("t2_line", 0, 8'h10, 4'd2, 8'd3, 1, 0);
        check("t2_addr3", 32'(bus_if.addr), 32'h13);
        check("t2_cout3", 32'(bus_if.cout_addr_generator), 1);
        cyc("t2_wrap", 0, 8'h10, 4'd2, 8'd3, 1, 0);
        check("t2_line_wrap", 32'(bus_if.line_idx), 0);

        // Window advance and wrap to first window
        cyc("t3_w1", 0, 8'h10, 4'd2, 8'd3, 0, 1);
        check("t3_addr_w1", 32'(bus_if.addr), 32'h12);
        cyc("t3_w2", 0, 8'h10, 4'd2, 8'd3, 0, 1);
        check("t3_addr_w2", 32'(bus_if.addr), 32'h14);
        check("t3_done_w2", 32'(bus_if.ld_window_done), 1);
        cyc("t3_w0", 0, 8'h10, 4'd2, 8'd3, 0, 1);
        check("t3_addr_w0", 32'(bus_if.addr), 32'h10);

        // Both enables on the last line of window 0
        for (int i = 0; i < 3; i++) cyc("t4_line", 0, 8'h10, 4'd2, 8'd3, 1, 0);
        cyc("t4_both", 0, 8'h10, 4'd2, 8'd3, 1, 1);
        check("t4_addr", 32'(bus_if.addr), 32'h12);

        // Address wraps past the top of memory
        cyc("t5_start", 1, 8'hFE, 4'd1, 8'd4, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t5_line", 0, 8'hFE, 4'd1, 8'd4, 1, 0);
        check("t5_addr_wrap", 32'(bus_if.addr), 32'h01);

        // Restart mid-window; enables in the start cycle must be ignored
        cyc("t6_mid", 0, 8'hFE, 4'd1, 8'd4, 0, 1);
        cyc("t6_start", 1, 8'h40, 4'd3, 8'd0, 1, 1);
        check("t6_addr", 32'(bus_if.addr), 32'h40);
        check("t6_done", 32'(bus_if.ld_window_done), 1);
        cyc("t6_w", 0, 8'h40, 4'd3, 8'd0, 0, 1);
        check("t6_addr_single", 32'(bus_if.addr), 32'h40);

        // Asynchronous reset while mid-count
        cyc("t1_start", 1, 8'h20, 4'd3, 8'd5, 0, 0);
        cyc("t1_line", 0, 8'h20, 4'd3, 8'd5, 1, 1);
        cyc("t1_line", 0, 8'h20, 4'd3, 8'd5, 1, 0);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("t1_async");
        @(negedge clk);
        rst = 1'b1;

        // Random traffic with occasional restarts
        for (int i = 0; i < 600; i++) begin
            logic s;
            s = ($urandom_range(0, 24) == 0) || (i == 0);
            cyc("rnd", s, addr_t'($urandom), stride_t'($urandom),
                pos_t'($urandom_range(0, 6)), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
